// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle barrel shifter with a valid/ready handshake on both sides.
// The operand is shifted by at most STEP bit positions per clock until the
// requested amount is used up. The result is then held until the consumer takes it.
module shifter_seq #(
  parameter  int XLEN = 32,
  parameter  int STEP = 4,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op1,
  input  logic [SHW-1:0]  i_op2,
  input  logic [2:0]      i_mode,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // Codes 5-7 are reserved and fall through to SLL in the step datapath.
  typedef enum logic [2:0] {
    M_SLL = 3'd0,
    M_SRL = 3'd1,
    M_SRA = 3'd2,
    M_ROL = 3'd3,
    M_ROR = 3'd4
  } mode_t;

  // One extra bit so that STEP == XLEN and the rotate complement both fit.
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
  localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] work;
  logic [SHW-1:0]  rem;
  logic [2:0]      mode;

  logic            accept;
  logic            step_en;
  logic            load_res;
  logic [SHW:0]    amt;
  logic [SHW:0]    amt_inv;
  logic [SHW-1:0]  rem_next;
  logic [XLEN-1:0] work_step;

  // Handshake flags come straight from the state register, never from inputs.
  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: all state is written with <= so every register samples the
      // pre-edge values of its peers, regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state logic and datapath enables; kill takes priority everywhere.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    load_res   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_valid && !i_kill) begin
          accept     = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_kill) begin
          state_next = S_IDLE;
        end else if (rem != '0) begin
          step_en = 1'b1;
        end else begin
          load_res   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (i_kill || i_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-cycle shift distance: a full STEP while enough remains, else the tail.
  always_comb begin
    if ({1'b0, rem} >= STEP_W) begin
      amt = STEP_W;
    end else begin
      amt = {1'b0, rem};
    end
    amt_inv  = XLEN_W - amt;
    // amt never exceeds rem, so its top bit is clear whenever it matters here.
    rem_next = rem - amt[SHW-1:0];
  end

  // One shift step of the work register by amt, according to the captured mode.
  // SRA keeps the MSB in place, so the original sign bit fills every step.
  // Rotates by 0 reduce to work | (work >> XLEN) == work.
  always_comb begin
    work_step = work << amt;
    case (mode)
      M_SLL:   work_step = work << amt;
      M_SRL:   work_step = work >> amt;
      M_SRA:   work_step = $signed(work) >>> amt;
      M_ROL:   work_step = (work << amt) | (work >> amt_inv);
      M_ROR:   work_step = (work >> amt) | (work << amt_inv);
      default: work_step = work << amt;
    endcase
  end

  // Work/remaining/mode registers: loaded on accept, advanced on each step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: datapath registers are reset as well as the FSM so that the
      // visible result and the internal state are deterministic after reset.
      work <= '0;
      rem  <= '0;
      mode <= '0;
    end else if (accept) begin
      work <= i_op1;
      rem  <= i_op2;
      mode <= i_mode;
    end else if (step_en) begin
      work <= work_step;
      rem  <= rem_next;
    end
  end

  // Result register: written once per completed operation, held otherwise,
  // so it cannot move while o_valid is high or after a kill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result <= '0;
    end else if (load_res) begin
      o_result <= work;
    end
  end

`ifdef DISCRETE_FORMAL
  // Copy of the accepted request, used only by the properties below.
  logic [XLEN-1:0] f_op;
  logic [SHW-1:0]  f_n;
  logic [2:0]      f_mode;
  logic [XLEN-1:0] f_ref;

  // Capture the request alongside the datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_op   <= '0;
      f_n    <= '0;
      f_mode <= '0;
    end else if (accept) begin
      f_op   <= i_op1;
      f_n    <= i_op2;
      f_mode <= i_mode;
    end
  end

  // Single-shot reference shift of the captured operand.
  always_comb begin
    f_ref = f_op << f_n;
    case (f_mode)
      M_SRL:   f_ref = f_op >> f_n;
      M_SRA:   f_ref = $signed(f_op) >>> f_n;
      M_ROL:   f_ref = (f_n == '0) ? f_op : ((f_op << f_n) | (f_op >> (XLEN_W - {1'b0, f_n})));
      M_ROR:   f_ref = (f_n == '0) ? f_op : ((f_op >> f_n) | (f_op << (XLEN_W - {1'b0, f_n})));
      default: f_ref = f_op << f_n;
    endcase
  end

  a_mode_legal: assume property (@(posedge i_clk) disable iff (i_rst)
    (i_valid && o_ready) |-> (i_mode <= 3'd4));
  a_result_ok: assert property (@(posedge i_clk) disable iff (i_rst)
    o_valid |-> (o_result == f_ref));
  a_excl: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_ready && o_valid));
  a_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> $stable(o_result));
`endif

endmodule
